tone_seq_player: RTL and testbench

Parametrised successor to the single-octave buzzer: a square-wave tone generator with chromatic notes, selectable octave, PWM volume and per-note millisecond duration, fed by a valid/ready note stream. Sits between a song/keyboard sequencer and the speaker pin. It plays back-to-back notes gaplessly and reports completion, so an auto-play block can stream a melody without timing its own delays.

---
 rtl/tone_pkg.sv | 49 ++++
 rtl/ms_timer.sv | 56 +++++
 rtl/tone_seq_player.sv | 154 +++++++++++++++
 tb/tb_tone_seq_player.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: note codes, the C3 octave pitch
// table (milli-hertz) and the elaboration-time half-period calculation.
package tone_pkg;

    // Chromatic note codes; anything outside C..B plays as a rest.
    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
        NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B
    } note_e;

    localparam int unsigned NUM_NOTES = 12;

    // Pitch of each note in octave 0 (C3..B3), in milli-hertz.
    function automatic int unsigned mhz_c3(input int unsigned note);
        case (note)
            32'd1:   return 32'd130813;
            32'd2:   return 32'd138591;
            32'd3:   return 32'd146832;
            32'd4:   return 32'd155563;
            32'd5:   return 32'd164814;
            32'd6:   return 32'd174614;
            32'd7:   return 32'd184997;
            32'd8:   return 32'd195998;
            32'd9:   return 32'd207652;
            32'd10:  return 32'd220000;
            32'd11:  return 32'd233082;
            32'd12:  return 32'd246942;
            default: return 32'd0;
        endcase
    endfunction

    // Rounded half-period in clock cycles; higher octaves truncate via the shift.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned note,
                                                input int unsigned oct);
        longint unsigned num;
        longint unsigned den;
        if (note < 32'd1 || note > NUM_NOTES) return 32'd0;
        num = 64'(clk_hz) * 64'd1000;
        den = 64'(mhz_c3(note)) * 64'd2;
        return 32'(((num + (den / 64'd2)) / den) >> oct);
    endfunction

    function automatic logic is_rest(input logic [3:0] note);
        return (note < NOTE_C) || (note > NOTE_B);
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Note duration timer: a millisecond prescaler feeding a millisecond
// down-counter. `last` flags the final clock cycle of the loaded duration
// (a zero duration is final immediately).
//   clk, rst : clock, synchronous active-high reset
//   load     : restart with duration `dur` (wins over clear)
//   clear    : return to the all-zero idle condition
//   dur      : duration in ms, sampled on load
//   last     : decoded from registers, high in the final cycle
module ms_timer #(
    parameter int unsigned MS_CYC = 100_000,
    parameter int unsigned DUR_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [DUR_W-1:0] dur,
    output logic             last
);
    localparam int unsigned     PRE_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_CYC - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DUR_W-1:0] ms_q, ms_d;

    // Prescaler wraps every MS_CYC cycles and decrements the ms count.
    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if (load) begin
            pre_d = '0;
            ms_d  = dur;
        end else if (clear) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (ms_q != '0) ms_d = ms_q - DUR_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

    assign last = (ms_q == '0) || ((ms_q == DUR_W'(1)) && (pre_q == PRE_MAX));

endmodule

// File: rtl/tone_seq_player.sv
// Square-wave note player fed by a valid/ready note stream. Plays chromatic
// notes over NUM_OCT octaves with PWM volume and millisecond durations,
// gapless back-to-back, with a done pulse in each note's final cycle.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : note request valid       in_ready : request accepted this cycle
//   in_note   : 0/13-15 rest, 1-12 C..B  in_oct   : octave (clamped)
//   in_dur    : duration in ms           in_vol   : PWM volume, 0 = mute
//   stop      : abort current note       busy     : note or rest in progress
//   done      : final cycle of a note    speaker  : registered audio output
module tone_seq_player #(
    parameter int unsigned  CLK_HZ  = 100_000_000,
    parameter int unsigned  NUM_OCT = 3,
    parameter int unsigned  CNT_W   = 19,
    parameter int unsigned  DUR_W   = 12,
    parameter int unsigned  VOL_W   = 3,
    localparam int unsigned OCT_W   = (NUM_OCT > 1) ? $clog2(NUM_OCT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_note,
    input  logic [OCT_W-1:0] in_oct,
    input  logic [DUR_W-1:0] in_dur,
    input  logic [VOL_W-1:0] in_vol,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             speaker
);
    import tone_pkg::*;

    localparam int unsigned MS_CYC  = CLK_HZ / 1000;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_PLAY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [VOL_W-1:0] car_q, car_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             tone_q, tone_d;
    logic             rest_q, rest_d;
    logic             spk_q, spk_d;
    logic             tm_load, tm_clear, tm_last;
    logic             play, accept;
    logic [OCT_W-1:0] oct_eff;

    // Octave-0 half-periods indexed by raw note code; rest codes hold 0.
    logic [CNT_W-1:0] base_half [16];
    for (genvar n = 0; n < 16; n++) begin : g_half
        localparam logic [CNT_W-1:0] HALF = CNT_W'(half_period(CLK_HZ, 32'(n), 32'd0));
        assign base_half[n] = HALF;
    end

    assign oct_eff  = (32'(in_oct) >= NUM_OCT) ? OCT_W'(NUM_OCT - 1) : in_oct;
    assign play     = (state_q == ST_PLAY);
    assign in_ready = !play || tm_last;
    // stop outranks a request landing in the final cycle.
    assign accept   = in_valid && in_ready && !(play && stop);

    ms_timer #(
        .MS_CYC (MS_CYC),
        .DUR_W  (DUR_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tm_load),
        .clear (tm_clear),
        .dur   (in_dur),
        .last  (tm_last)
    );

    // Next state, tone divider, PWM carrier and input latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        car_d    = car_q + VOL_W'(1);
        half_d   = half_q;
        rest_d   = rest_q;
        vol_d    = vol_q;
        tm_load  = 1'b0;
        tm_clear = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (rest_q) begin
                    cnt_d  = '0;
                    tone_d = 1'b0;
                end else if (cnt_q == half_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    tone_d = !tone_q;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end
                if (stop || tm_last) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    tone_d   = 1'b0;
                    car_d    = '0;
                    tm_clear = 1'b1;
                end
            end
            default: begin
                cnt_d    = '0;
                tone_d   = 1'b0;
                car_d    = '0;
                tm_clear = 1'b1;
            end
        endcase

        // Every accepted note restarts tone, carrier and timer at phase 0.
        if (accept) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            tone_d  = 1'b0;
            car_d   = '0;
            half_d  = base_half[in_note] >> oct_eff;
            rest_d  = is_rest(in_note);
            vol_d   = in_vol;
            tm_load = 1'b1;
        end

        spk_d = (state_d == ST_PLAY) & tone_d & (car_d < vol_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            car_q   <= '0;
            vol_q   <= '0;
            tone_q  <= 1'b0;
            rest_q  <= 1'b0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            car_q   <= car_d;
            vol_q   <= vol_d;
            tone_q  <= tone_d;
            rest_q  <= rest_d;
            spk_q   <= spk_d;
        end
    end

    assign busy    = play;
    assign done    = play && tm_last;
    assign speaker = spk_q;

endmodule

// File: tb/tb_tone_seq_player.sv
// Directed bench for tone_seq_player at CLK_HZ = 1 MHz (1000 cycles per ms).
// Expected half-periods are hand-computed from the pitch table:
//   C oct0 3822, C oct1 1911, C oct2 955, D oct2 851,
//   A oct0 2273, A oct2 568, B oct1 1012.
module tb_tone_seq_player;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int          MS     = 1000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_note;
    logic [1:0]  in_oct;
    logic [11:0] in_dur;
    logic [2:0]  in_vol;
    logic        stop;
    logic        busy;
    logic        done;
    logic        speaker;

    tone_seq_player #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_note  (in_note),
        .in_oct   (in_oct),
        .in_dur   (in_dur),
        .in_vol   (in_vol),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .speaker  (speaker)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  note;
        logic [1:0]  oct;
        logic [11:0] dur;
        logic [2:0]  vol;
        int          h;    // expected half-period, 0 = silent tone
        int          len;  // expected PLAY length in cycles
    } vec_t;

    vec_t vecs [10];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Speaker at PLAY offset k (k = 1 is the cycle after acceptance).
    function automatic logic model_spk(input int h, input logic [2:0] vol, input int k);
        if (h == 0) return 1'b0;
        return (((k - 1) / h) % 2 == 1) && (((k - 1) % 8) < int'(vol));
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int spk_bad, first_bad, done_at, done_cnt, busy_bad, rdy_bad;
        spk_bad = 0; first_bad = -1; done_at = -1; done_cnt = 0; busy_bad = 0; rdy_bad = 0;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_note = v.note; in_oct = v.oct; in_dur = v.dur; in_vol = v.vol;
        for (int k = 1; k <= v.len; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (speaker !== model_spk(v.h, v.vol, k)) begin
                spk_bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin done_cnt++; done_at = k; end
            if (in_ready !== 1'(k == v.len)) rdy_bad++;
        end
        if (first_bad >= 0)
            $display("v%0d first speaker difference at offset %0d", idx, first_bad);
        check($sformatf("v%0d_spk_trace_bad", idx), 32'(spk_bad), 32'd0);
        check($sformatf("v%0d_busy_bad", idx), 32'(busy_bad), 32'd0);
        check($sformatf("v%0d_ready_bad", idx), 32'(rdy_bad), 32'd0);
        check($sformatf("v%0d_done_count", idx), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d_done_offset", idx), 32'(done_at), 32'(v.len));
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_idle_spk", idx), 32'(speaker), 32'd0);
        check($sformatf("v%0d_idle_done", idx), 32'(done), 32'd0);
    endtask

    initial begin
        int bb_busy_bad, bb_spk_bad, bb_done1, bb_done2, kk, seen_done, seen_busy;
        logic bb_idle_busy;

        vecs[0] = '{4'd1,  2'd1, 12'd2, 3'd7, 1911, 2000};
        vecs[1] = '{4'd10, 2'd0, 12'd3, 3'd7, 2273, 3000};
        vecs[2] = '{4'd10, 2'd2, 12'd1, 3'd5, 568,  1000};
        vecs[3] = '{4'd10, 2'd3, 12'd1, 3'd3, 568,  1000};  // octave clamps to 2
        vecs[4] = '{4'd12, 2'd1, 12'd2, 3'd6, 1012, 2000};
        vecs[5] = '{4'd0,  2'd0, 12'd3, 3'd7, 0,    3000};  // rest
        vecs[6] = '{4'd14, 2'd0, 12'd1, 3'd7, 0,    1000};  // out-of-range note rests
        vecs[7] = '{4'd1,  2'd2, 12'd1, 3'd0, 955,  1000};  // mute
        vecs[8] = '{4'd5,  2'd0, 12'd0, 3'd7, 0,    1};     // zero duration
        vecs[9] = '{4'd3,  2'd2, 12'd1, 3'd1, 851,  1000};

        rst = 1'b1; in_valid = 1'b0; in_note = '0; in_oct = '0; in_dur = '0; in_vol = '0; stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_spk", 32'(speaker), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: valid held high, second note taken in the done cycle.
        bb_busy_bad = 0; bb_spk_bad = 0; bb_done1 = -1; bb_done2 = -1; bb_idle_busy = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_note = 4'd10; in_oct = 2'd2; in_dur = 12'd1; in_vol = 3'd7;
        for (int k = 1; k <= 2 * MS + 1; k++) begin
            @(negedge clk);
            if (k <= 2 * MS) begin
                kk = (k > MS) ? k - MS : k;
                if (busy !== 1'b1) bb_busy_bad++;
                if (speaker !== model_spk(568, 3'd7, kk)) bb_spk_bad++;
                if (done === 1'b1) begin
                    if (k <= MS) bb_done1 = k; else bb_done2 = k;
                end
            end else begin
                bb_idle_busy = busy;
            end
            if (k == MS + 1) in_valid = 1'b0;
        end
        check("b2b_busy_gap", 32'(bb_busy_bad), 32'd0);
        check("b2b_spk_phase", 32'(bb_spk_bad), 32'd0);
        check("b2b_done1", 32'(bb_done1), 32'(MS));
        check("b2b_done2", 32'(bb_done2), 32'(2 * MS));
        check("b2b_idle_busy", 32'(bb_idle_busy), 32'd0);

        // stop mid-note together with a new request.
        @(negedge clk);
        in_valid = 1'b1; in_note = 4'd10; in_oct = 2'd2; in_dur = 12'd2; in_vol = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (699) @(negedge clk);
        check("stop_pre_spk", 32'(speaker), 32'd1);
        stop = 1'b1; in_valid = 1'b1; in_note = 4'd1; in_dur = 12'd1;
        @(negedge clk);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_spk", 32'(speaker), 32'd0);
        check("stop_ready", 32'(in_ready), 32'd1);
        check("stop_done", 32'(done), 32'd0);
        stop = 1'b0; in_valid = 1'b0;
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (busy !== 1'b0) seen_busy++;
        end
        check("stop_no_done", 32'(seen_done), 32'd0);
        check("stop_not_accepted", 32'(seen_busy), 32'd0);

        // Reset mid-note.
        @(negedge clk);
        in_valid = 1'b1; in_note = 4'd10; in_oct = 2'd2; in_dur = 12'd2; in_vol = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (699) @(negedge clk);
        check("rstmid_pre_spk", 32'(speaker), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_spk", 32'(speaker), 32'd0);
        check("rstmid_ready", 32'(in_ready), 32'd1);
        check("rstmid_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_after_busy", 32'(busy), 32'd0);

        // stop in IDLE is ignored; the request is taken (zero-length note).
        stop = 1'b1; in_valid = 1'b1; in_note = 4'd5; in_oct = 2'd0; in_dur = 12'd0; in_vol = 3'd7;
        @(negedge clk);
        check("idlestop_busy", 32'(busy), 32'd1);
        check("idlestop_done", 32'(done), 32'd1);
        check("idlestop_spk", 32'(speaker), 32'd0);
        stop = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idlestop_end_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
